// File: rtl/seg_scan_if.sv
// Bus between a pattern requester and the 7-segment scan driver.
// The master owns pattern/enable/update; the slave owns display lines and pulses.
interface seg_scan_if;
  logic [63:0] seg_trans;
  logic [7:0]  digit_en;
  logic        update;
  logic [7:0]  seg_out;
  logic [7:0]  an_out;
  logic        update_ack;
  logic        frame_done;

  modport master (
    output seg_trans, digit_en, update,
    input  seg_out, an_out, update_ack, frame_done
  );

  modport slave (
    input  seg_trans, digit_en, update,
    output seg_out, an_out, update_ack, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit 7-segment scanner with dead-time blanking between digits
// and a shadow pattern that only updates at frame boundaries.
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_eff;
  logic [2:0]    idx, idx_nx;
  logic [63:0]   pat_sh, pat_sh_nx;
  logic [7:0]    en_sh, en_sh_nx;
  logic [7:0]    seg_q, seg_nx;
  logic [7:0]    an_q, an_nx;
  logic          ack_q, ack_nx;
  logic          fd_q, fd_nx;

  assign bus.seg_out    = seg_q;
  assign bus.an_out     = an_q;
  assign bus.update_ack = ack_q;
  assign bus.frame_done = fd_q;

  // Next-state, counter, shadow capture and next registered outputs
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    pat_sh_nx = pat_sh;
    en_sh_nx  = en_sh;
    seg_nx    = 8'hFF;
    an_nx     = 8'hFF;
    ack_nx    = 1'b0;
    fd_nx     = 1'b0;

    // A zero count only occurs straight out of reset; treat it as a fresh BLANK load
    cnt_eff = (state == BLANK && cnt == '0) ? CW'(DEAD_CYCLES) : cnt;

    if (cnt_eff == CW'(1)) begin
      if (state == BLANK) begin
        state_nx = SHOW;
        cnt_nx   = CW'(REFRESH_DIV);
      end else begin
        state_nx = BLANK;
        cnt_nx   = CW'(DEAD_CYCLES);
        idx_nx   = idx + 3'd1;
        if (idx == 3'd7) begin
          fd_nx = 1'b1;
          if (bus.update) begin
            pat_sh_nx = bus.seg_trans;
            en_sh_nx  = bus.digit_en;
            ack_nx    = 1'b1;
          end
        end
      end
    end else begin
      cnt_nx = cnt_eff - CW'(1);
    end

    if (state_nx == SHOW && en_sh[idx_nx]) begin
      an_nx  = ~(8'd1 << idx_nx);
      seg_nx = pat_sh[{idx_nx, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= BLANK;
      cnt    <= '0;
      idx    <= '0;
      pat_sh <= {8{8'hFF}};
      en_sh  <= '0;
      seg_q  <= 8'hFF;
      an_q   <= 8'hFF;
      ack_q  <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      pat_sh <= pat_sh_nx;
      en_sh  <= en_sh_nx;
      seg_q  <= seg_nx;
      an_q   <= an_nx;
      ack_q  <= ack_nx;
      fd_q   <= fd_nx;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: frame-position model checked every cycle, plus
// hand-computed literal checks at chosen cycles of each scenario.
module tb_seg_scan_driver;

  localparam int REF   = 4;
  localparam int DEAD  = 2;
  localparam int SLOT  = REF + DEAD;
  localparam int FRAME = 8 * SLOT;

  localparam logic [63:0] PA = 64'hF9A4B099_92F88090;
  localparam logic [63:0] PB = 64'h8899AABB_CCDDEEF1;
  localparam logic [63:0] PC = 64'h0102030405060708;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_if bus ();

  seg_scan_driver #(.REFRESH_DIV(REF), .DEAD_CYCLES(DEAD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int u     = 0;
  bit mvalid = 1'b0;

  logic [63:0] m_pat;
  logic [7:0]  m_en;
  logic [7:0]  e_seg, e_an;
  logic        e_ack, e_fd;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at u=%0d: got %h expected %h", name, u, act, exp);
    end
  endtask

  // Model: output after each edge depends only on position within the frame and the shadow copy
  always @(posedge clk) begin
    int p, slot, off;
    logic r, upd;
    logic [63:0] st;
    logic [7:0]  de;
    r = rst; upd = bus.update; st = bus.seg_trans; de = bus.digit_en;
    if (r) begin
      u = 0; mvalid = 1'b1;
      m_pat = {8{8'hFF}}; m_en = 8'h00;
      e_seg = 8'hFF; e_an = 8'hFF; e_ack = 1'b0; e_fd = 1'b0;
    end else if (mvalid) begin
      u++;
      p = u % FRAME; slot = p / SLOT; off = p % SLOT;
      e_fd  = (p == 0);
      e_ack = e_fd && upd;
      if (e_ack) begin
        m_pat = st;
        m_en  = de;
      end
      e_seg = 8'hFF; e_an = 8'hFF;
      if (off >= DEAD && m_en[slot]) begin
        e_an  = 8'hFF ^ (8'h01 << slot);
        e_seg = 8'(m_pat >> (8 * slot));
      end
    end
    #1;
    if (mvalid) begin
      chk("seg_out",    bus.seg_out, e_seg);
      chk("an_out",     bus.an_out,  e_an);
      chk("update_ack", {7'b0, bus.update_ack}, {7'b0, e_ack});
      chk("frame_done", {7'b0, bus.frame_done}, {7'b0, e_fd});
    end
  end

  task automatic wait_u(input int target);
    int k;
    k = 0;
    while (u != target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (u != target) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_u: got u=%0d expected %0d", u, target);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.update = 1'b0; bus.seg_trans = '0; bus.digit_en = '0;
    repeat (3) @(negedge clk);
    chk("rst_seg", bus.seg_out, 8'hFF);
    chk("rst_an",  bus.an_out,  8'hFF);
    chk("rst_ack", {7'b0, bus.update_ack}, 8'h00);
    chk("rst_fd",  {7'b0, bus.frame_done}, 8'h00);

    // Capture PA at the first boundary; digit0 slot dark beforehand
    rst = 1'b0; bus.update = 1'b1; bus.seg_trans = PA; bus.digit_en = 8'hFF;
    wait_u(2);  chk("dark_d0_an", bus.an_out, 8'hFF);
    wait_u(48);
    chk("b1_fd",  {7'b0, bus.frame_done}, 8'h01);
    chk("b1_ack", {7'b0, bus.update_ack}, 8'h01);
    bus.update = 1'b0;
    wait_u(50); chk("d0_an", bus.an_out, 8'hFE); chk("d0_seg", bus.seg_out, 8'h90);
    wait_u(56); chk("d1_an", bus.an_out, 8'hFD); chk("d1_seg", bus.seg_out, 8'h80);
    wait_u(92); chk("d7_an", bus.an_out, 8'h7F); chk("d7_seg", bus.seg_out, 8'hF9);

    // Enable only digits 0..3
    bus.update = 1'b1; bus.digit_en = 8'h0F;
    wait_u(96); chk("en_ack", {7'b0, bus.update_ack}, 8'h01);
    bus.update = 1'b0; bus.digit_en = 8'hFF;
    wait_u(116); chk("d3_an", bus.an_out, 8'hF7); chk("d3_seg", bus.seg_out, 8'h92);
    wait_u(122); chk("d4_an", bus.an_out, 8'hFF); chk("d4_seg", bus.seg_out, 8'hFF);

    // New pattern requested mid-frame lands only at the boundary
    wait_u(154);
    bus.seg_trans = PB; bus.update = 1'b1;
    wait_u(160); chk("old_an", bus.an_out, 8'hFB); chk("old_seg", bus.seg_out, 8'hF8);
    wait_u(192);
    chk("pb_ack", {7'b0, bus.update_ack}, 8'h01);
    chk("pb_fd",  {7'b0, bus.frame_done}, 8'h01);
    bus.update = 1'b0;
    wait_u(194); chk("pb_an", bus.an_out, 8'hFE); chk("pb_seg", bus.seg_out, 8'hF1);

    // Withdrawn request: no capture, no ack
    wait_u(212);
    bus.seg_trans = PC; bus.update = 1'b1;
    repeat (3) @(negedge clk);
    bus.update = 1'b0;
    wait_u(240);
    chk("wd_ack", {7'b0, bus.update_ack}, 8'h00);
    chk("wd_fd",  {7'b0, bus.frame_done}, 8'h01);
    wait_u(242); chk("wd_an", bus.an_out, 8'hFE); chk("wd_seg", bus.seg_out, 8'hF1);

    // Reset in digit3 SHOW
    wait_u(261); chk("pre_rst_an", bus.an_out, 8'hF7); chk("pre_rst_seg", bus.seg_out, 8'hCC);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_an", bus.an_out, 8'hFF); chk("mid_rst_seg", bus.seg_out, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    wait_u(2);  chk("post_rst_an", bus.an_out, 8'hFF);
    wait_u(8);  chk("post_rst_d1_an", bus.an_out, 8'hFF); chk("post_rst_d1_seg", bus.seg_out, 8'hFF);
    wait_u(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
